acq_trigger_sampler: RTL and testbench

Parametrised successor to the current ACSP sampling front end. It divides `system_clock` to a sample tick and waits, once armed, for a rise, fall or level trigger on the probe inputs. After the trigger it streams a bounded or continuous run of samples to the capture FIFO over a valid/ready handshake. Optional edge compression, overflow detection and timestamps let the same block serve wide and narrow probe configurations.

---
 rtl/acq_trigger_sampler.sv | 169 ++++++++++++++++
 tb/tb_acq_trigger_sampler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_trigger_sampler.sv
// Divided-tick trigger sampler: arm, wait for edge/level trigger, stream samples over valid/ready.
// Optional define ACQ_TIMESTAMP_EN adds sample_time, the tick index since the trigger.
module acq_trigger_sampler #(
    parameter int CHANNELS    = 8,
    parameter int DIV_WIDTH   = 24,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   system_clock,
    input  logic                   reset_n,
    input  logic [CHANNELS-1:0]    data_in,
    input  logic [DIV_WIDTH-1:0]   divider,
    input  logic [CHANNELS-1:0]    rise_pattern,
    input  logic [CHANNELS-1:0]    fall_pattern,
    input  logic [CHANNELS-1:0]    level_mask,
    input  logic [CHANNELS-1:0]    level_value,
    input  logic                   edge_capture,
    input  logic [COUNT_WIDTH-1:0] post_count,
    input  logic                   arm,
    input  logic                   abort,
    output logic                   armed,
    output logic                   run,
    output logic                   done,
    output logic                   overflow,
    output logic [CHANNELS-1:0]    sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready
`ifdef ACQ_TIMESTAMP_EN
    ,
    output logic [COUNT_WIDTH-1:0] sample_time
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [DIV_WIDTH-1:0]   div_reg;
    logic [DIV_WIDTH-1:0]   div_cnt_reg;
    logic [CHANNELS-1:0]    rise_reg;
    logic [CHANNELS-1:0]    fall_reg;
    logic [CHANNELS-1:0]    lmask_reg;
    logic [CHANNELS-1:0]    lval_reg;
    logic [CHANNELS-1:0]    prev_reg;
    logic                   ec_reg;
    logic                   first_reg;
    logic [COUNT_WIDTH-1:0] post_reg;
    logic [COUNT_WIDTH-1:0] tick_cnt_reg;

    logic                   active;
    logic                   tick;
    logic                   edge_mode;
    logic                   edge_hit;
    logic                   level_hit;
    logic                   trigger;
    logic [COUNT_WIDTH-1:0] tick_cnt_next;
    logic                   final_tick;
    logic                   run_emit;
    logic                   emit;
    logic                   drop;

    assign armed = (state_reg == S_ARMED);
    assign run   = (state_reg == S_RUN);
    assign done  = (state_reg == S_DONE);

    assign active    = (state_reg == S_ARMED) || (state_reg == S_RUN);
    assign tick      = active && (div_cnt_reg == '0);
    assign edge_mode = |(rise_reg | fall_reg);
    assign edge_hit  = (|(rise_reg & ~prev_reg & data_in)) || (|(fall_reg & prev_reg & ~data_in));
    assign level_hit = (((data_in ^ lval_reg) & lmask_reg) == '0);
    // prev is stale on the first tick after arm, so edges cannot fire there
    assign trigger   = tick && (state_reg == S_ARMED) &&
                       (edge_mode ? (edge_hit && !first_reg) : level_hit);

    assign tick_cnt_next = tick_cnt_reg + 1'b1;
    assign final_tick    = tick && (state_reg == S_RUN) && (post_reg != '0) &&
                           (tick_cnt_next == post_reg);
    assign run_emit      = tick && (state_reg == S_RUN) &&
                           (!ec_reg || (data_in != prev_reg) || final_tick);
    assign emit          = trigger || run_emit;
    assign drop          = emit && sample_valid && !sample_ready;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            div_reg      <= '0;
            div_cnt_reg  <= '0;
            rise_reg     <= '0;
            fall_reg     <= '0;
            lmask_reg    <= '0;
            lval_reg     <= '0;
            prev_reg     <= '0;
            ec_reg       <= 1'b0;
            first_reg    <= 1'b0;
            post_reg     <= '0;
            tick_cnt_reg <= '0;
            overflow     <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
`ifdef ACQ_TIMESTAMP_EN
            sample_time  <= '0;
`endif
        end else if (abort) begin
            state_reg    <= S_IDLE;
            sample_valid <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_reg    <= S_ARMED;
                        div_reg      <= divider;
                        div_cnt_reg  <= divider;
                        rise_reg     <= rise_pattern;
                        fall_reg     <= fall_pattern;
                        lmask_reg    <= level_mask;
                        lval_reg     <= level_value;
                        ec_reg       <= edge_capture;
                        post_reg     <= post_count;
                        first_reg    <= 1'b1;
                        tick_cnt_reg <= '0;
                        overflow     <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        state_reg    <= (post_reg == COUNT_WIDTH'(1)) ? S_DONE : S_RUN;
                        tick_cnt_reg <= COUNT_WIDTH'(1);
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        tick_cnt_reg <= tick_cnt_next;
                    end
                    if (final_tick) begin
                        state_reg <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (tick) begin
                div_cnt_reg <= div_reg;
                prev_reg    <= data_in;
                first_reg   <= 1'b0;
            end else if (active) begin
                div_cnt_reg <= div_cnt_reg - 1'b1;
            end

            // a same-cycle accept frees the holding register, so the new sample can load
            if (emit && !drop) begin
                sample_data  <= data_in;
                sample_valid <= 1'b1;
`ifdef ACQ_TIMESTAMP_EN
                sample_time  <= trigger ? '0 : tick_cnt_reg;
`endif
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acq_trigger_sampler.sv
// Bench for acq_trigger_sampler: scenario-level model of tick times, trigger and emissions,
// per-cycle compare, plus literal expectations for backpressure, abort and reset.
module tb_acq_trigger_sampler;

    localparam int CH   = 8;
    localparam int DW   = 8;
    localparam int CW   = 5;
    localparam int MAXL = 64;

    logic           system_clock = 1'b0;
    logic           reset_n      = 1'b0;
    logic [CH-1:0]  data_in      = '0;
    logic [DW-1:0]  divider      = '0;
    logic [CH-1:0]  rise_pattern = '0;
    logic [CH-1:0]  fall_pattern = '0;
    logic [CH-1:0]  level_mask   = '0;
    logic [CH-1:0]  level_value  = '0;
    logic           edge_capture = 1'b0;
    logic [CW-1:0]  post_count   = '0;
    logic           arm          = 1'b0;
    logic           abort        = 1'b0;
    logic           sample_ready = 1'b1;
    logic           armed, run, done, overflow, sample_valid;
    logic [CH-1:0]  sample_data;
`ifdef ACQ_TIMESTAMP_EN
    logic [CW-1:0]  sample_time;
`endif

    acq_trigger_sampler #(.CHANNELS(CH), .DIV_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .divider      (divider),
        .rise_pattern (rise_pattern),
        .fall_pattern (fall_pattern),
        .level_mask   (level_mask),
        .level_value  (level_value),
        .edge_capture (edge_capture),
        .post_count   (post_count),
        .arm          (arm),
        .abort        (abort),
        .armed        (armed),
        .run          (run),
        .done         (done),
        .overflow     (overflow),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
`ifdef ACQ_TIMESTAMP_EN
        ,
        .sample_time  (sample_time)
`endif
    );

    always #5 system_clock = ~system_clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // scenario stimulus (edge 0 = arm edge) and model expectations for the cycle after each edge
    logic [CH-1:0] dat       [MAXL];
    int            exp_st    [MAXL];   // 1 armed, 2 run, 3 done
    bit            exp_valid [MAXL];
    logic [CH-1:0] exp_data  [MAXL];
    int            exp_time  [MAXL];

    int            cur    = 0;
    bit            chk_en = 1'b0;
    int            obs_n  = 0;
    int            obs_edge [MAXL];
    logic [CH-1:0] obs_data [MAXL];
    int            obs_time [MAXL];

    always @(negedge system_clock) begin
        if (chk_en) begin
            check("armed",    32'(armed),        32'(exp_st[cur] == 1));
            check("run",      32'(run),          32'(exp_st[cur] == 2));
            check("done",     32'(done),         32'(exp_st[cur] == 3));
            check("valid",    32'(sample_valid), 32'(exp_valid[cur]));
            check("overflow", 32'(overflow),     32'(0));
            if (exp_valid[cur]) begin
                check("data", 32'(sample_data), 32'(exp_data[cur]));
`ifdef ACQ_TIMESTAMP_EN
                check("time", 32'(sample_time), 32'(exp_time[cur]));
`endif
            end
            if (sample_valid && obs_n < MAXL) begin
                obs_edge[obs_n] = cur;
                obs_data[obs_n] = sample_data;
`ifdef ACQ_TIMESTAMP_EN
                obs_time[obs_n] = int'(sample_time);
                $display("txn edge=%0d data=%02h time=%0d", cur, sample_data, sample_time);
`else
                obs_time[obs_n] = 0;
                $display("txn edge=%0d data=%02h", cur, sample_data);
`endif
                obs_n++;
            end
        end
    end

    // Model: ticks fall on edges d+1, 2(d+1), ...; walk them applying trigger/emission rules.
    task automatic run_scn(input int d, input logic [CH-1:0] ri, input logic [CH-1:0] fa,
                           input logic [CH-1:0] lm, input logic [CH-1:0] lv,
                           input logic ec, input int post, input int len);
        int st, cnt, tm;
        bit first, trig, fin, ev, is_tick;
        logic [CH-1:0] prv;
        st = 1; cnt = 0; tm = 0;
        for (int i = 0; i < len; i++) begin
            ev = 0;
            is_tick = (i >= d + 1) && (((i - d - 1) % (d + 1)) == 0);
            if (is_tick && (st == 1 || st == 2)) begin
                first = (i == d + 1);
                prv   = first ? '0 : dat[i - d - 1];
                if (st == 1) begin
                    if ((ri | fa) != 0)
                        trig = !first && (((ri & ~prv & dat[i]) != 0) || ((fa & prv & ~dat[i]) != 0));
                    else
                        trig = (((dat[i] ^ lv) & lm) == 0);
                    if (trig) begin
                        ev = 1; tm = 0; cnt = 1;
                        st = (post == 1) ? 3 : 2;
                    end
                end else begin
                    tm  = cnt;
                    cnt = cnt + 1;
                    fin = (post != 0) && (cnt == post);
                    ev  = !ec || (dat[i] != prv) || fin;
                    if (fin) st = 3;
                end
            end
            exp_st[i]    = st;
            exp_valid[i] = ev;
            exp_data[i]  = dat[i];
            exp_time[i]  = tm % (1 << CW);
        end

        obs_n = 0;
        for (int i = 0; i < len; i++) begin
            data_in = dat[i];
            if (i == 0) begin
                arm = 1; divider = DW'(d); rise_pattern = ri; fall_pattern = fa;
                level_mask = lm; level_value = lv; edge_capture = ec; post_count = CW'(post);
            end else begin
                // configuration changes after arm must have no effect
                arm = 0; divider = DW'(d + 3); rise_pattern = ~ri; fall_pattern = ~fa;
                level_mask = ~lm; level_value = ~lv; edge_capture = ~ec; post_count = CW'(post + 7);
            end
            @(posedge system_clock); #2;
            cur = i; chk_en = 1'b1;
        end
        @(negedge system_clock); #1;
        chk_en = 1'b0;
        arm = 0;
    endtask

    initial begin
        #1;
        check("rst_armed", 32'(armed), 32'(0));
        check("rst_run",   32'(run),   32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_ovf",   32'(overflow), 32'(0));
        check("rst_valid", 32'(sample_valid), 32'(0));
        check("rst_data",  32'(sample_data), 32'(0));
        repeat (2) @(posedge system_clock);
        #2 reset_n = 1'b1;

        // level mode, every tick, divider 4, 5 ticks
        for (int i = 0; i < MAXL; i++) dat[i] = CH'(8'h10 + i);
        run_scn(4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5, 40);
        check("lvl_count",  32'(obs_n), 32'(5));
        check("lvl_edge0",  32'(obs_edge[0]), 32'(5));
        check("lvl_data0",  32'(obs_data[0]), 32'(8'h15));
        check("lvl_edge4",  32'(obs_edge[4]), 32'(25));
        check("lvl_data4",  32'(obs_data[4]), 32'(8'h29));
        check("lvl_done",   32'(done), 32'(1));

        // fall trigger at divider 0
        for (int i = 0; i < MAXL; i++) dat[i] = (i < 10) ? 8'hFF : 8'h00;
        run_scn(0, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 3, 20);
        check("fall_count", 32'(obs_n), 32'(3));
        check("fall_edge0", 32'(obs_edge[0]), 32'(10));
        check("fall_data0", 32'(obs_data[0]), 32'(8'h00));

        // edge compression: bit 1 changes at run ticks 3 and 7
        for (int i = 0; i < MAXL; i++)
            dat[i] = CH'(((i >= 6) ? 1 : 0) | ((i >= 11 && i < 19) ? 2 : 0));
        run_scn(1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 20, 50);
        check("ec_count", 32'(obs_n), 32'(4));
        check("ec_edge1", 32'(obs_edge[1]), 32'(12));
        check("ec_data1", 32'(obs_data[1]), 32'(8'h03));
        check("ec_edge2", 32'(obs_edge[2]), 32'(20));
        check("ec_edge3", 32'(obs_edge[3]), 32'(44));

        // continuous run past the count wrap
        for (int i = 0; i < MAXL; i++) dat[i] = CH'($urandom_range(0, 255));
        run_scn(0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 45);
        check("cont_count", 32'(obs_n), 32'(44));
`ifdef ACQ_TIMESTAMP_EN
        check("ts_31",  32'(obs_time[31]), 32'(31));
        check("ts_wrap", 32'(obs_time[32]), 32'(0));
`endif

        // abort and arm together mid-run
        check("pre_abort_run", 32'(run), 32'(1));
        arm = 1; abort = 1;
        @(posedge system_clock); #2;
        arm = 0; abort = 0;
        check("abort_armed", 32'(armed), 32'(0));
        check("abort_run",   32'(run), 32'(0));
        check("abort_valid", 32'(sample_valid), 32'(0));
        @(posedge system_clock); #2;
        check("abort_stay",  32'(sample_valid | run | armed), 32'(0));

        // backpressure: ready low for three ticks at divider 0
        sample_ready = 0; data_in = 8'hA0; arm = 1; divider = '0;
        rise_pattern = '0; fall_pattern = '0; level_mask = '0; level_value = '0;
        edge_capture = 0; post_count = '0;
        @(posedge system_clock); #2;
        arm = 0;
        for (int e = 1; e <= 4; e++) begin
            data_in = CH'(8'hA0 + e);
            sample_ready = (e == 4);
            @(posedge system_clock); #2;
            check("bp_valid", 32'(sample_valid), 32'(1));
            check("bp_data",  32'(sample_data), (e == 4) ? 32'(8'hA4) : 32'(8'hA1));
            check("bp_ovf",   32'(overflow), (e >= 2) ? 32'(1) : 32'(0));
        end
        abort = 1;
        @(posedge system_clock); #2;
        abort = 0;
        check("bp_abort_valid", 32'(sample_valid), 32'(0));
        check("bp_abort_ovf",   32'(overflow), 32'(1));
        arm = 1;
        @(posedge system_clock); #2;
        arm = 0;
        check("bp_arm_ovf",   32'(overflow), 32'(0));
        check("bp_arm_armed", 32'(armed), 32'(1));

        // asynchronous reset mid-run
        sample_ready = 1;
        repeat (3) @(posedge system_clock);
        #2;
        check("pre_rst_run",   32'(run), 32'(1));
        check("pre_rst_valid", 32'(sample_valid), 32'(1));
        reset_n = 0;
        #1;
        check("arst_run",   32'(run), 32'(0));
        check("arst_armed", 32'(armed), 32'(0));
        check("arst_done",  32'(done), 32'(0));
        check("arst_valid", 32'(sample_valid), 32'(0));
        check("arst_data",  32'(sample_data), 32'(0));
        @(posedge system_clock); #2;
        reset_n = 1;
        @(posedge system_clock); #2;
        check("post_rst_idle", 32'(armed | run | done), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
